// File: rtl/b_dis.sv
// Display back-end for the 8-bit calculator: picks entry/result/error text and
// drives a time-multiplexed 4-digit common-anode 7-segment display.
module b_dis #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       i_sys_clock,
    input  logic       i_sys_reset,
    input  logic       i_b_dis_result_overflow_flag,
    input  logic       i_b_dis_hex_overflow_flag,
    input  logic       i_b_dis_op_valid_key_pressed,
    input  logic       i_b_dis_equal,
    input  logic       i_b_dis_neg_flag,
    input  logic       i_b_dis_neg_result,
    input  logic [7:0] i_b_dis_result,
    input  logic [7:0] i_b_dis_hex_keycode,
    output logic [6:0] o_b_dis_dis_code,
    output logic [3:0] o_b_dis_sel
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_L     = 7'h47;

    typedef enum logic [1:0] {
        MODE_OFL,
        MODE_ERR,
        MODE_RESULT,
        MODE_ENTRY
    } mode_t;

    mode_t         mode;
    logic [7:0]    value;
    logic          sign;
    logic [19:0]   dd;
    logic [3:0]    hund;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic [6:0]    glyph;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        mode  = MODE_ENTRY;
        value = i_b_dis_hex_keycode;
        sign  = i_b_dis_neg_flag;
        if (i_b_dis_result_overflow_flag) begin
            mode = MODE_OFL;
        end else if (i_b_dis_hex_overflow_flag) begin
            mode = MODE_ERR;
        end else if (i_b_dis_equal || i_b_dis_op_valid_key_pressed) begin
            mode  = MODE_RESULT;
            value = i_b_dis_result;
            sign  = i_b_dis_neg_result;
        end
    end

    // Double-dabble: binary in dd[7:0], BCD accumulates in dd[19:8].
    always_comb begin
        dd = {12'd0, value};
        for (int unsigned i = 0; i < 8; i++) begin
            if (dd[11:8]  >= 4'd5) dd[11:8]  = dd[11:8]  + 4'd3;
            if (dd[15:12] >= 4'd5) dd[15:12] = dd[15:12] + 4'd3;
            if (dd[19:16] >= 4'd5) dd[19:16] = dd[19:16] + 4'd3;
            dd = dd << 1;
        end
        hund  = dd[19:16];
        tens  = dd[15:12];
        units = dd[11:8];
    end

    always_comb begin
        glyph = SEG_BLANK;
        case (mode)
            MODE_OFL: begin
                case (idx)
                    2'd2:    glyph = SEG_O;
                    2'd1:    glyph = SEG_F;
                    2'd0:    glyph = SEG_L;
                    default: glyph = SEG_BLANK;
                endcase
            end
            MODE_ERR: begin
                case (idx)
                    2'd2:    glyph = SEG_E;
                    2'd1:    glyph = SEG_R;
                    2'd0:    glyph = SEG_R;
                    default: glyph = SEG_BLANK;
                endcase
            end
            default: begin
                case (idx)
                    2'd3:    glyph = sign ? SEG_MINUS : SEG_BLANK;
                    2'd2:    glyph = (hund != 4'd0) ? seg7(hund) : SEG_BLANK;
                    2'd1:    glyph = (hund != 4'd0 || tens != 4'd0) ? seg7(tens) : SEG_BLANK;
                    default: glyph = seg7(units);
                endcase
            end
        endcase
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            scan_cnt         <= '0;
            idx              <= '0;
            o_b_dis_sel      <= '1;
            o_b_dis_dis_code <= '1;
        end else begin
            o_b_dis_sel      <= ~(4'b0001 << idx);
            o_b_dis_dis_code <= glyph;
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_b_dis.sv
// Bench for b_dis with SCAN_DIV = 1: directed display cases then random inputs,
// compared against an arithmetic model of the display text.
module tb_b_dis;

    logic       clk = 1'b0;
    logic       rst;
    logic       rovf, hovf, opk, eq, negf, negr;
    logic [7:0] result, keycode;
    logic [6:0] dis_code;
    logic [3:0] sel;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    logic [6:0] digit_seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] ofl_txt [4] = '{7'h47, 7'h0E, 7'h40, 7'h7F};
    logic [6:0] err_txt [4] = '{7'h2F, 7'h2F, 7'h06, 7'h7F};

    b_dis #(.SCAN_DIV(1)) dut (
        .i_sys_clock                  (clk),
        .i_sys_reset                  (rst),
        .i_b_dis_result_overflow_flag (rovf),
        .i_b_dis_hex_overflow_flag    (hovf),
        .i_b_dis_op_valid_key_pressed (opk),
        .i_b_dis_equal                (eq),
        .i_b_dis_neg_flag             (negf),
        .i_b_dis_neg_result           (negr),
        .i_b_dis_result               (result),
        .i_b_dis_hex_keycode          (keycode),
        .o_b_dis_dis_code             (dis_code),
        .o_b_dis_sel                  (sel)
    );

    always #5 clk = ~clk;

    // pos 0 = rightmost digit
    function automatic logic [6:0] ref_glyph(input int pos);
        int v;
        bit s;
        if (rovf) return ofl_txt[pos];
        if (hovf) return err_txt[pos];
        if (eq || opk) begin v = int'(result);  s = negr; end
        else           begin v = int'(keycode); s = negf; end
        case (pos)
            3: return s ? 7'h3F : 7'h7F;
            2: return (v >= 100) ? digit_seg[v / 100] : 7'h7F;
            1: return (v >= 10) ? digit_seg[(v / 10) % 10] : 7'h7F;
            default: return digit_seg[v % 10];
        endcase
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_cycle(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        check(tag, {sel, dis_code}, {4'hF, 7'h7F});
        k = 0;
    endtask

    // One scan step: each edge shows digit k (cycling), glyph from current inputs.
    task automatic step(input string tag);
        logic [3:0] exp_sel;
        logic [6:0] exp_code;
        rst = 1'b0;
        exp_sel  = ~(4'b0001 << k);
        exp_code = ref_glyph(k);
        @(posedge clk); #1;
        check(tag, {sel, dis_code}, {exp_sel, exp_code});
        k = (k + 1) % 4;
    endtask

    task automatic frame(input string tag);
        for (int i = 0; i < 4; i++) step(tag);
    endtask

    task automatic set_in(input logic ro, input logic ho, input logic o, input logic e,
                          input logic nf, input logic nr, input logic [7:0] r, input logic [7:0] kc);
        rovf = ro; hovf = ho; opk = o; eq = e; negf = nf; negr = nr; result = r; keycode = kc;
    endtask

    initial begin
        int vals [5] = '{0, 9, 10, 99, 255};
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) reset_cycle("reset");

        set_in(0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        frame("scan_zero");
        set_in(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        frame("ofl");
        set_in(1, 1, 0, 0, 0, 0, 8'd0, 8'd0);
        frame("ofl_both");
        set_in(0, 1, 0, 0, 0, 0, 8'd0, 8'd0);
        frame("err");
        set_in(0, 0, 0, 0, 0, 0, 8'd0, 8'h64);
        frame("key100");
        set_in(0, 0, 0, 0, 1, 0, 8'd0, 8'h64);
        frame("key100_neg");
        set_in(0, 0, 1, 0, 0, 0, 8'h42, 8'h07);
        frame("op66");
        set_in(0, 0, 0, 1, 0, 1, 8'h42, 8'h07);
        frame("eq66_neg");
        foreach (vals[i]) begin
            set_in(0, 0, 0, 0, 0, 0, 8'd0, 8'(vals[i]));
            frame("sweep_key");
            set_in(0, 0, 0, 1, 0, 0, 8'(vals[i]), 8'd0);
            frame("sweep_res");
        end

        step("midscan_a");
        reset_cycle("midscan_reset");
        frame("after_reset");

        for (int n = 0; n < 150; n++) begin
            set_in(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   8'($urandom), 8'($urandom));
            step("random");
            if ($urandom_range(0, 40) == 0) reset_cycle("random_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
